bus_port_fifo_bank: RTL
=======================

# bus_port_fifo_bank

Parametrised bank of per-driver FIFO pairs between the bus agents and `bs_gnrtr_n_rbtr`. It replaces the single-word, behavioural per-driver queues with synthesizable storage.

- Each of `drvrs` ports gets a TX FIFO: agent writes; the bus drains it through `pndng`/`pop`/`D_pop`.
- Each port also gets an RX FIFO: the bus fills it through `push`/`D_push`; the agent reads it.
- Configurable depth, configurable overflow policy, occupancy counters and sticky error flags.

## Interface
- `drvrs`, default 4: number of bus ports.
- `pckg_sz`, default 16: packet width in bits.
- `depth`, default 8: entries per FIFO; power of two, minimum 2.
- `ovf_mode`, default 0: policy when a write hits a full FIFO. 0 = drop the new word. 1 = overwrite the oldest word.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all pointers, counts and flags.
- `ag_wr` in `drvrs`: agent write strobe into TX FIFO i.
- `ag_din` in `drvrs*pckg_sz`: agent write data; slice i is `[i*pckg_sz +: pckg_sz]`.
- `ag_rd` in `drvrs`: agent read strobe from RX FIFO i.
- `ag_dout` out `drvrs*pckg_sz`: RX head word (first-word fall-through).
- `ag_full` out `drvrs`: TX FIFO i full.
- `ag_empty` out `drvrs`: RX FIFO i empty.
- `pndng` out `drvrs`: TX FIFO i non-empty; to the DUT.
- `D_pop` out `drvrs*pckg_sz`: TX head word (first-word fall-through).
- `pop` in `drvrs`: DUT pop of TX FIFO i.
- `push` in `drvrs`: DUT push into RX FIFO i.
- `D_push` in `drvrs*pckg_sz`: DUT push data.
- `tx_cnt` out `drvrs*($clog2(depth)+1)`: TX occupancy.
- `rx_cnt` out `drvrs*($clog2(depth)+1)`: RX occupancy.
- `ovf` out `2*drvrs`: sticky overflow flags; bit i = TX i, bit `drvrs+i` = RX i.
- `udf` out `2*drvrs`: sticky underflow flags; same bit layout as `ovf`.
- `err_clr` in 1: synchronous clear of all `ovf`/`udf` bits.

## Operation
- All 2×`drvrs` FIFOs are independent, identical instances.
- Write side: TX is written by `ag_wr`, RX by `push`.
- Read side: TX is read by `pop`, RX by `ag_rd`.
- Write, not full: store the word at `wr_ptr`, increment `wr_ptr` and the count.
- Write while full, `ovf_mode`=0: word discarded, pointers and count unchanged, `ovf` bit set.
- Write while full, `ovf_mode`=1: word overwrites the head, both pointers advance, count stays at `depth`, `ovf` bit set.
- Read, not empty: increment `rd_ptr`, decrement the count.
- Read while empty: ignored, `udf` bit set.
- Simultaneous read and write while empty: the read is an underflow and the write proceeds; count becomes 1.
- Simultaneous read and write while full: both proceed; count unchanged; no `ovf`, regardless of `ovf_mode`.
- Simultaneous read and write otherwise: both proceed; count unchanged.
- Pointers are `$clog2(depth)` bits and wrap modulo `depth`. Full/empty come from the count register, never from pointer comparison.
- `err_clr` has priority over a same-cycle set of a flag; the flag reads 0 afterwards.

## Timing
- Reset values:
  - all counts 0;
  - `pndng` 0, `ag_full` 0, `ag_empty` all 1;
  - `ovf`/`udf` 0;
  - `D_pop`/`ag_dout` 0, since storage is cleared on reset.
- Write-to-visible latency is 1 cycle: a write at edge N gives `pndng`/`~ag_empty` high and valid head data after edge N.
- Heads are registered-storage reads; the head changes only after a read edge. Pop at edge N shows the next word after N.
- All flags and counts update on the same edge as the causing strobe.
- `reset` asserted mid-transfer empties every FIFO immediately and asynchronously. In-flight words are lost and no flags are set.

## Structure
- Package `bus_fifo_pkg`: `ovf_mode` encodings (`OVF_DROP`=0, `OVF_OVERWRITE`=1) and a `cnt_w(depth)` width function.
- One sub-module, `sync_fifo_fwft`, parametrised by `pckg_sz`, `depth` and `ovf_mode`, with ports wr/din/rd/dout/full/empty/cnt/ovf_pulse/udf_pulse.
- The top generates 2×`drvrs` instances and holds the sticky flag registers.

## Test plan
- Reset then idle: all outputs at their reset values; `ag_empty`=4'hF.
- Fill TX0 with 0x0001..0x0008, then pop 8 times: `D_pop` returns 0x0001..0x0008 in order; `pndng[0]` drops after the 8th pop; `tx_cnt[0]` goes 8→0.
- `ovf_mode`=0: 9 pushes of 0xA0..0xA8 into RX2; `ovf[6]`=1; reads return 0xA0..0xA7 only.
- `ovf_mode`=1: same stimulus; reads return 0xA1..0xA8; count stays 8.
- Simultaneous push and `ag_rd` on a full RX1: count stays 8 and `ovf[5]` stays 0. Pop on an empty TX3: `udf[3]`=1; `err_clr` clears it next edge.
- Assert `reset` mid-fill with 5 words in TX1: `tx_cnt[1]`=0 and `pndng[1]`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bus_fifo_pkg.sv
// Shared encodings and sizing helpers for the bus port FIFO bank.
package bus_fifo_pkg;

  typedef enum logic {
    OVF_DROP      = 1'b0,
    OVF_OVERWRITE = 1'b1
  } ovf_mode_e;

  // Occupancy needs one extra bit so that a full FIFO (count == depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bus_port_fifo_bank_if.sv
// Agent/bus-side signal bundle of the FIFO bank; slice i of every vector belongs to port i.
interface bus_port_fifo_bank_if
  import bus_fifo_pkg::*;
#(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16,
  parameter int depth   = 8
);
  localparam int CW = cnt_w(depth);

  logic [drvrs-1:0]               ag_wr;
  logic [drvrs-1:0][pckg_sz-1:0]  ag_din;
  logic [drvrs-1:0]               ag_rd;
  logic [drvrs-1:0][pckg_sz-1:0]  ag_dout;
  logic [drvrs-1:0]               ag_full;
  logic [drvrs-1:0]               ag_empty;
  logic [drvrs-1:0]               pndng;
  logic [drvrs-1:0][pckg_sz-1:0]  D_pop;
  logic [drvrs-1:0]               pop;
  logic [drvrs-1:0]               push;
  logic [drvrs-1:0][pckg_sz-1:0]  D_push;
  logic [drvrs-1:0][CW-1:0]       tx_cnt;
  logic [drvrs-1:0][CW-1:0]       rx_cnt;
  logic [2*drvrs-1:0]             ovf;
  logic [2*drvrs-1:0]             udf;
  logic                           err_clr;

  modport slave (
    input  ag_wr, ag_din, ag_rd, pop, push, D_push, err_clr,
    output ag_dout, ag_full, ag_empty, pndng, D_pop, tx_cnt, rx_cnt, ovf, udf
  );

  modport master (
    output ag_wr, ag_din, ag_rd, pop, push, D_push, err_clr,
    input  ag_dout, ag_full, ag_empty, pndng, D_pop, tx_cnt, rx_cnt, ovf, udf
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; full/empty derive from the count register only.
module sync_fifo_fwft
  import bus_fifo_pkg::*;
#(
  parameter int        pckg_sz  = 16,
  parameter int        depth    = 8,
  parameter ovf_mode_e ovf_mode = OVF_DROP,
  localparam int       AW       = $clog2(depth),
  localparam int       CW       = cnt_w(depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [pckg_sz-1:0] din,
  input  logic               rd,
  output logic [pckg_sz-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      cnt,
  output logic               ovf_pulse,
  output logic               udf_pulse
);
  localparam bit OVW = (ovf_mode == OVF_OVERWRITE);

  logic [depth-1:0][pckg_sz-1:0] mem_q, mem_d;
  logic [AW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          do_wr, do_rd;

  always_comb begin
    full      = (cnt_q == CW'(depth));
    empty     = (cnt_q == '0);
    // A concurrent read frees the slot, so a write into a full FIFO only overflows without one.
    do_wr     = wr & (~full | rd | OVW);
    do_rd     = (rd & ~empty) | (wr & full & ~rd & OVW);
    ovf_pulse = wr & full & ~rd;
    udf_pulse = rd & empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = mem_q[rd_ptr_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/bus_port_fifo_bank.sv
// Bank of per-port TX/RX FIFO pairs between the bus agents and the arbiter, with sticky error flags.
module bus_port_fifo_bank
  import bus_fifo_pkg::*;
#(
  parameter int        drvrs    = 4,
  parameter int        pckg_sz  = 16,
  parameter int        depth    = 8,
  parameter ovf_mode_e ovf_mode = OVF_DROP
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_port_fifo_bank_if.slave  bus
);
  logic [drvrs-1:0]   tx_empty, rx_full_unused;
  logic [2*drvrs-1:0] ovf_p, udf_p;
  logic [2*drvrs-1:0] ovf_q, ovf_d, udf_q, udf_d;

  for (genvar i = 0; i < drvrs; i++) begin : g_port
    sync_fifo_fwft #(.pckg_sz(pckg_sz), .depth(depth), .ovf_mode(ovf_mode)) u_tx (
      .clk(clk), .reset(reset),
      .wr(bus.ag_wr[i]), .din(bus.ag_din[i]),
      .rd(bus.pop[i]),   .dout(bus.D_pop[i]),
      .full(bus.ag_full[i]), .empty(tx_empty[i]), .cnt(bus.tx_cnt[i]),
      .ovf_pulse(ovf_p[i]), .udf_pulse(udf_p[i])
    );

    sync_fifo_fwft #(.pckg_sz(pckg_sz), .depth(depth), .ovf_mode(ovf_mode)) u_rx (
      .clk(clk), .reset(reset),
      .wr(bus.push[i]),  .din(bus.D_push[i]),
      .rd(bus.ag_rd[i]), .dout(bus.ag_dout[i]),
      .full(rx_full_unused[i]), .empty(bus.ag_empty[i]), .cnt(bus.rx_cnt[i]),
      .ovf_pulse(ovf_p[drvrs+i]), .udf_pulse(udf_p[drvrs+i])
    );

    assign bus.pndng[i] = ~tx_empty[i];
  end

  // Clear wins over a same-cycle set so software never sees a stale flag after clearing.
  always_comb begin
    ovf_d = ovf_q | ovf_p;
    udf_d = udf_q | udf_p;
    if (bus.err_clr) begin
      ovf_d = '0;
      udf_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;

endmodule
